// File: rtl/mxv_seq.sv
// Sequential handshaked signed matrix-vector multiplier: N_OUT MAC lanes, one matrix row per clock.
// Optional MXV_SAT_EN clamps out-of-range lanes instead of truncating them.
module mxv_seq #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 3,
  parameter int N_OUT  = 5,
  parameter int ACC_W  = 2*DATA_W + $clog2(N_IN+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] matrix [0:N_IN-1][0:N_OUT-1],
  input  logic signed [DATA_W-1:0] vector [0:N_IN-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] result [0:N_OUT-1],
  output logic                     ovf,
  output logic                     busy
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic                       last;
  logic signed [DATA_W-1:0]   mreg [0:N_IN-1][0:N_OUT-1];
  logic signed [DATA_W-1:0]   vreg [0:N_IN-1];
  logic signed [ACC_W-1:0]    acc      [0:N_OUT-1];
  logic signed [ACC_W-1:0]    acc_nxt  [0:N_OUT-1];
  logic signed [2*DATA_W-1:0] op_a     [0:N_OUT-1];
  logic signed [2*DATA_W-1:0] op_b     [0:N_OUT-1];
  logic signed [2*DATA_W-1:0] prod     [0:N_OUT-1];
  logic signed [ACC_W-1:0]    prod_ext [0:N_OUT-1];
  logic [ACC_W-DATA_W:0]      hi       [0:N_OUT-1];
  logic                       lane_ovf [0:N_OUT-1];
  logic [DATA_W-1:0]          lane_res [0:N_OUT-1];
  logic                       ovf_nxt;

  assign last = (idx == IDX_W'(N_IN-1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_CALC;
      end
      S_CALC: if (last) state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands widened to 2*DATA_W before multiplying so the product is exact.
  always_comb begin
    ovf_nxt = 1'b0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      op_a[j]     = mreg[idx][j];
      op_b[j]     = vreg[idx];
      prod[j]     = op_a[j] * op_b[j];
      prod_ext[j] = prod[j];
      acc_nxt[j]  = acc[j] + prod_ext[j];
      // A lane fits in DATA_W only when every bit from the DATA_W sign bit up agrees.
      hi[j]       = acc_nxt[j][ACC_W-1:DATA_W-1];
      lane_ovf[j] = !((&hi[j]) || !(|hi[j]));
      ovf_nxt     = ovf_nxt | lane_ovf[j];
`ifdef MXV_SAT_EN
      lane_res[j] = lane_ovf[j] ? (acc_nxt[j][ACC_W-1] ? MINV : MAXV)
                                : acc_nxt[j][DATA_W-1:0];
`else
      lane_res[j] = acc_nxt[j][DATA_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      ovf   <= 1'b0;
      for (int unsigned j = 0; j < N_OUT; j++) begin
        acc[j]    <= '0;
        result[j] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (in_valid) begin
          mreg <= matrix;
          vreg <= vector;
          idx  <= '0;
          for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= '0;
        end
        S_CALC: begin
          for (int unsigned j = 0; j < N_OUT; j++) acc[j] <= acc_nxt[j];
          if (last) begin
            // Final sum goes straight to the output registers so DONE presents it at once.
            for (int unsigned j = 0; j < N_OUT; j++) result[j] <= lane_res[j];
            ovf <= ovf_nxt;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_seq.sv
// Directed self-checking bench for mxv_seq: default instance plus a DATA_W=8, N_IN=1, N_OUT=2 instance.
module tb_mxv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, ovf, busy;
  logic signed [31:0] matrix [0:2][0:4];
  logic signed [31:0] vector [0:2];
  logic signed [31:0] result [0:4];

  logic in_valid1, in_ready1, out_valid1, out_ready1, ovf1, busy1;
  logic signed [7:0] matrix1 [0:0][0:1];
  logic signed [7:0] vector1 [0:0];
  logic signed [7:0] result1 [0:1];

  int n_checks = 0;
  int n_fail   = 0;

  mxv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .matrix(matrix), .vector(vector), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .busy(busy)
  );

  mxv_seq #(.DATA_W(8), .N_IN(1), .N_OUT(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .matrix(matrix1), .vector(vector1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .ovf(ovf1), .busy(busy1)
  );

  task automatic set_basic();
    for (int i = 0; i < 3; i++) begin
      vector[i] = i + 1;
      for (int j = 0; j < 5; j++) matrix[i][j] = i + j;
    end
  endtask

  task automatic start_txn();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1;
    set_basic();
    matrix1[0][0] = 0; matrix1[0][1] = 0; vector1[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, ovf} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 1000", {in_ready, out_valid, busy, ovf});
    end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (result[j] !== 32'sd0) begin
        n_fail++; $display("FAIL reset_result[%0d]: got %0d expected 0", j, result[j]);
      end
    end
    n_checks++;
    if ({in_ready1, out_valid1, busy1, ovf1, result1[0], result1[1]} !== {4'b1000, 16'h0}) begin
      n_fail++; $display("FAIL reset_dut1: got %b %0d %0d expected 1000 0 0",
                         {in_ready1, out_valid1, busy1, ovf1}, result1[0], result1[1]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n;
    set_basic(); out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready0: got %b expected 1", in_ready); end
    start_txn();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_out(n);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", n); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (result[j] !== 32'(8 + 6*j)) begin
        n_fail++; $display("FAIL basic_result[%0d]: got %0d expected %0d", j, result[j], 8 + 6*j);
      end
    end
    n_checks++;
    if ({ovf, in_ready} !== 2'b00) begin n_fail++; $display("FAIL basic_ovf_ready: got %b expected 00", {ovf, in_ready}); end
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL basic_return_idle: got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_signed();
    int n;
    for (int i = 0; i < 3; i++) begin
      vector[i] = i - 1;
      for (int j = 0; j < 5; j++) matrix[i][j] = 10*i + j;
    end
    start_txn();
    wait_out(n);
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (result[j] !== 32'sd20) begin
        n_fail++; $display("FAIL signed_result[%0d]: got %0d expected 20", j, result[j]);
      end
    end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL signed_ovf: got %b expected 0", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    set_basic(); out_ready = 1'b0;
    start_txn();
    wait_out(n);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      for (int i = 0; i < 3; i++) begin
        vector[i] = 100 + k;
        for (int j = 0; j < 5; j++) matrix[i][j] = -7 * (k + 1);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, ovf} !== 3'b100) begin
        n_fail++; $display("FAIL bp_ctrl[%0d]: got %b expected 100", k, {out_valid, in_ready, ovf});
      end
      for (int j = 0; j < 5; j++) begin
        n_checks++;
        if (result[j] !== 32'(8 + 6*j)) begin
          n_fail++; $display("FAIL bp_result[%0d][%0d]: got %0d expected %0d", k, j, result[j], 8 + 6*j);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++; $display("FAIL bp_release: got %b expected 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_overflow();
    int n;
    logic signed [31:0] exp_v;
`ifdef MXV_SAT_EN
    exp_v = 32'sh7FFFFFFF;
`else
    exp_v = 32'sd3;
`endif
    for (int i = 0; i < 3; i++) begin
      vector[i] = 32'sh7FFFFFFF;
      for (int j = 0; j < 5; j++) matrix[i][j] = 32'sh7FFFFFFF;
    end
    start_txn();
    wait_out(n);
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (result[j] !== exp_v) begin
        n_fail++; $display("FAIL ovf_result[%0d]: got %h expected %h", j, result[j], exp_v);
      end
    end
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    logic signed [31:0] held;
`ifdef MXV_SAT_EN
    held = 32'sh7FFFFFFF;
`else
    held = 32'sd3;
`endif
    set_basic();
    start_txn();
    n_checks++;
    if (result[2] !== held || ovf !== 1'b1) begin
      n_fail++; $display("FAIL hold_in_calc: got %h/%b expected %h/1", result[2], ovf, held);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, ovf} !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %b expected 1000", {in_ready, out_valid, busy, ovf});
    end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (result[j] !== 32'sd0) begin n_fail++; $display("FAIL rstmid_result[%0d]: got %0d expected 0", j, result[j]); end
    end
    start_txn();
    wait_out(n);
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 4", n); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (result[j] !== 32'(8 + 6*j)) begin
        n_fail++; $display("FAIL rstmid_after[%0d]: got %0d expected %0d", j, result[j], 8 + 6*j);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    first = -1; second = -1;
    set_basic(); out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (in_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      n_checks++;
      if (in_ready && out_valid) begin n_fail++; $display("FAIL b2b_exclusive[%0d]: got 11 expected not both", c); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (first !== 0 || second !== 5) begin
      n_fail++; $display("FAIL b2b_period: got accepts %0d,%0d expected 0,5", first, second);
    end
    wait_out(n);
    @(posedge clk); #1;
  endtask

  task automatic test_param();
    int n;
    logic signed [7:0] exp0;
`ifdef MXV_SAT_EN
    exp0 = 8'sd127;
`else
    exp0 = -8'sd128;
`endif
    matrix1[0][0] = -8'sd128; matrix1[0][1] = 8'sd127; vector1[0] = -8'sd1;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 1;
    while (!out_valid1 && n < 40) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n !== 2) begin n_fail++; $display("FAIL param_latency: got %0d expected 2", n); end
    n_checks++;
    if (result1[0] !== exp0) begin n_fail++; $display("FAIL param_result0: got %0d expected %0d", result1[0], exp0); end
    n_checks++;
    if (result1[1] !== -8'sd127) begin n_fail++; $display("FAIL param_result1: got %0d expected -127", result1[1]); end
    n_checks++;
    if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL param_ovf: got %b expected 1", ovf1); end
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready1, out_valid1} !== 2'b10) begin
      n_fail++; $display("FAIL param_idle: got %b expected 10", {in_ready1, out_valid1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
